// File: rtl/sound_sequencer.sv
// sound_sequencer: plays short melodies for the taximeter on the audio divider.
// Four requesters are served by fixed priority (bit 0 highest). Notes come
// from an internal melody ROM: each note drives a 32-bit division factor and
// gates the speaker with tone_en.
// Optional feature macro: SOUND_PREEMPT_EN. When it is defined, a pending
// request of higher priority aborts the melody that is playing.
// Reset: rst_n is asynchronous and active-high. The name is kept so it
// matches the rest of the codebase.

module sound_sequencer #(
  parameter int TICK_CYC = 50000,
  parameter int GAP_CYC  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  output logic [31:0] div_n,
  output logic        tone_en,
  output logic        busy,
  output logic [3:0]  grant,
  output logic        done
);

  localparam logic [19:0] TICK_W = 20'(TICK_CYC);
  localparam logic [19:0] GAP_W  = 20'(GAP_CYC);
  localparam logic [3:0]  CODE_END  = 4'hF;
  localparam logic [3:0]  CODE_REST = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_REST  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t      state_r;
  logic [3:0]  pend_r;
  logic [1:0]  gsel_r;
  logic [2:0]  idx_r;
  logic [19:0] cnt_r;
  logic [31:0] div_n_r;
  logic        tone_en_r;
  logic        busy_r;
  logic [3:0]  grant_r;
  logic        done_r;

  logic [7:0]  rom_s;
  logic [3:0]  code_s;
  logic [3:0]  dur_s;
  logic [19:0] dur_cyc_s;
  logic [3:0]  clr_s;
  logic        hi_s;
  logic        abort_s;

  // Melody ROM: entry = {code, dur}; code F ends the melody.
  function automatic logic [7:0] rom_f(input logic [1:0] mel, input logic [2:0] idx);
    logic [7:0] e;
    case ({mel, idx})
      5'b00_000: e = 8'h72;
      5'b00_001: e = 8'h02;
      5'b00_010: e = 8'h72;
      5'b00_011: e = 8'h02;
      5'b00_100: e = 8'hF0;
      5'b01_000: e = 8'h51;
      5'b01_001: e = 8'hF0;
      5'b10_000: e = 8'h12;
      5'b10_001: e = 8'h32;
      5'b10_010: e = 8'h52;
      5'b10_011: e = 8'hF0;
      5'b11_000: e = 8'h52;
      5'b11_001: e = 8'h32;
      5'b11_010: e = 8'h12;
      5'b11_011: e = 8'hF0;
      default:   e = 8'hF0;
    endcase
    return e;
  endfunction

  // Note code to divider factor (C5..B5 with a 1 MHz reference).
  function automatic logic [31:0] note_div_f(input logic [3:0] code);
    logic [31:0] d;
    case (code)
      4'd1:    d = 32'd1912;
      4'd2:    d = 32'd1703;
      4'd3:    d = 32'd1517;
      4'd4:    d = 32'd1433;
      4'd5:    d = 32'd1276;
      4'd6:    d = 32'd1136;
      4'd7:    d = 32'd1012;
      default: d = 32'd2;
    endcase
    return d;
  endfunction

  // Fixed priority: the lowest set index wins.
  function automatic logic [1:0] prio_f(input logic [3:0] p);
    logic [1:0] s;
    if (p[0])      s = 2'd0;
    else if (p[1]) s = 2'd1;
    else if (p[2]) s = 2'd2;
    else           s = 2'd3;
    return s;
  endfunction

  assign div_n   = div_n_r;
  assign tone_en = tone_en_r;
  assign busy    = busy_r;
  assign grant   = grant_r;
  assign done    = done_r;

  // Decode the ROM entry addressed by the granted melody and note index.
  always_comb begin
    rom_s     = rom_f(gsel_r, idx_r);
    code_s    = rom_s[7:4];
    dur_s     = rom_s[3:0];
    dur_cyc_s = 20'(dur_s) * TICK_W;
  end

  // Pending-bit clear mask on completion and the higher-priority abort decision.
  always_comb begin
    if (state_r == ST_DONE) begin
      clr_s = grant_r;
    end else begin
      clr_s = 4'd0;
    end
`ifdef SOUND_PREEMPT_EN
    hi_s = ((pend_r & (grant_r - 4'd1)) != 4'd0);
`else
    hi_s = 1'b0;
`endif
    if ((state_r == ST_FETCH) || (state_r == ST_PLAY) ||
        (state_r == ST_REST)  || (state_r == ST_GAP)) begin
      abort_s = hi_s;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Request capture, arbitration and note sequencing with registered outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r   <= ST_IDLE;
      pend_r    <= 4'd0;
      gsel_r    <= 2'd0;
      idx_r     <= 3'd0;
      cnt_r     <= 20'd0;
      div_n_r   <= 32'd2;
      tone_en_r <= 1'b0;
      busy_r    <= 1'b0;
      grant_r   <= 4'd0;
      done_r    <= 1'b0;
    end else begin
      // A new request on the clearing cycle keeps its bit set.
      pend_r <= (pend_r & ~clr_s) | req;
      done_r <= 1'b0;
      if (abort_s) begin
        // The aborted melody keeps its pend bit and restarts later from idx 0.
        state_r   <= ST_IDLE;
        tone_en_r <= 1'b0;
        busy_r    <= 1'b0;
        grant_r   <= 4'd0;
        cnt_r     <= 20'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (pend_r != 4'd0) begin
              gsel_r  <= prio_f(pend_r);
              grant_r <= 4'd1 << prio_f(pend_r);
              idx_r   <= 3'd0;
              busy_r  <= 1'b1;
              state_r <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (code_s == CODE_END) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else if (code_s == CODE_REST) begin
              cnt_r   <= dur_cyc_s;
              state_r <= ST_REST;
            end else begin
              div_n_r   <= note_div_f(code_s);
              tone_en_r <= 1'b1;
              cnt_r     <= dur_cyc_s;
              state_r   <= ST_PLAY;
            end
          end
          ST_PLAY, ST_REST: begin
            if (cnt_r <= 20'd1) begin
              tone_en_r <= 1'b0;
              cnt_r     <= GAP_W;
              state_r   <= ST_GAP;
            end else begin
              cnt_r <= cnt_r - 20'd1;
            end
          end
          ST_GAP: begin
            if (cnt_r <= 20'd1) begin
              idx_r   <= idx_r + 3'd1;
              cnt_r   <= 20'd0;
              state_r <= ST_FETCH;
            end else begin
              cnt_r <= cnt_r - 20'd1;
            end
          end
          ST_DONE: begin
            grant_r <= 4'd0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r   <= ST_IDLE;
            tone_en_r <= 1'b0;
            busy_r    <= 1'b0;
            grant_r   <= 4'd0;
            cnt_r     <= 20'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Plays short melodies (alarm, fare-step beep, start chime, stop chime) on the taximeter's audio divider. Arbitrates four sound requesters by fixed priority and sequences note codes from an internal melody ROM. For each note it drives the divider's 32-bit division factor plus a tone enable that gates the speaker. It sits between the meter control logic and the audio clock divider.

## Interface
- TICK_CYC, 50000: clk cycles per duration unit (50 ms at 1 MHz clk).
- GAP_CYC, 1000: silent clk cycles inserted after every note or rest.
- clk  in  1  system clock (1 MHz nominal).
- rst_n  in  1  asynchronous reset, active-high (name kept for codebase consistency).
- req  in  4  sound requests, one per melody; bit 0 = alarm (highest priority), 1 = fare beep, 2 = start chime, 3 = stop chime (lowest). Single-cycle pulses suffice.
- div_n  out  32  division factor for the audio divider.
- tone_en  out  1  speaker gate; high only while a note sounds.
- busy  out  1  high in any state other than IDLE.
- grant  out  4  one-hot melody currently playing; 0 when idle.
- done  out  1  one-cycle pulse when a melody completes.

## Operation
- Pending register pend[3:0]: a req bit high on a clk edge sets pend. The bit clears only in DONE for the granted melody; a new req on that same cycle wins and leaves pend set.
- ROM entry = {code[3:0], dur[3:0]}. Code 0 = rest, 1–7 = note, F = end of melody; dur 1–15 units.
- Melodies:
  - 0: (7,2) (0,2) (7,2) (0,2) F.
  - 1: (5,1) F.
  - 2: (1,2) (3,2) (5,2) F.
  - 3: (5,2) (3,2) (1,2) F.
- Note → div_n: 1 = 1912, 2 = 1703, 3 = 1517, 4 = 1433, 5 = 1276, 6 = 1136, 7 = 1012 (C5–B5 at 1 MHz).
- FSM:
  - IDLE: if pend ≠ 0, grant the lowest set index, idx ← 0, go to FETCH.
  - FETCH (1 cycle): read ROM[grant, idx]. Code F → DONE. Code 1–7 → load div_n, go to PLAY. Code 0 → REST; div_n holds its previous value.
  - PLAY / REST: run for dur×TICK_CYC cycles; tone_en = 1 in PLAY, 0 in REST. Then go to GAP.
  - GAP: run for GAP_CYC cycles with tone_en = 0, then idx ← idx+1 and go to FETCH.
  - DONE (1 cycle): done = 1, clear the granted pend bit, grant ← 0, go to IDLE.
- Cycle counter is 20 bits wide and counts down from the load value to 1. Duration product dur×TICK_CYC is computed in 20 bits; parameters must keep it ≤ 2^20−1.
- Requests arriving while busy stay pending and are served in priority order after DONE.

## Timing
- Reset values: div_n = 2, tone_en = 0, busy = 0, grant = 0, done = 0, pend = 0, state IDLE, counters 0.
- Request to sound: req on cycle t → pend set at t+1 → IDLE grants at t+2 → FETCH at t+2 → tone_en high from t+3.
- div_n changes in the same cycle tone_en rises, and never while tone_en is high.
- tone_en high for exactly dur×TICK_CYC cycles per note.
- Between consecutive notes: GAP_CYC + 1 low cycles (gap plus FETCH).
- done asserts 1 cycle after the FETCH that reads F. busy falls on the cycle after done.
- Reset mid-melody: all outputs return to reset values immediately (asynchronous); pending requests are lost.

## Configuration
- SOUND_PREEMPT_EN defined: in FETCH, PLAY, REST and GAP, a pend bit of higher priority than grant aborts the current melody.
  - Next cycle: tone_en = 0, the aborted pend bit stays set, go to IDLE with no done pulse.
  - The aborted melody restarts from idx 0 later.
- SOUND_PREEMPT_EN undefined: melodies always run to completion; higher-priority requests wait in pend.

## Test plan
- Reset then req = 4'b0010 pulse, TICK_CYC = 10, GAP_CYC = 3 → div_n = 1276, tone_en high 10 cycles, done pulse, grant returns to 0.
- req = 4'b0100 → div_n sequence 1912, 1517, 1276; each tone 20 cycles; 4-cycle low gaps between notes; done once.
- req = 4'b1001 simultaneously → alarm plays first (tone 7 → 1012, rests low 20 cycles), then stop chime 1276, 1517, 1912; two done pulses.
- Alarm req during stop chime, macro undefined → stop chime completes, then alarm plays. Macro defined → tone_en drops within 1 cycle, alarm starts, stop chime replays afterwards.
- rst_n high for 1 cycle mid-note → tone_en = 0, div_n = 2, busy = 0 immediately; no playback resumes.
- req bit 1 re-pulsed during its own DONE cycle → beep plays a second time.
